bit32_seq_divider: RTL

//  Multi-cycle 32-bit integer divider for the MIPS32 DIV/DIVU path.

---
 rtl/bit32_div_pkg.sv | 14 +
 rtl/bit32_ripple_carry_adder.sv | 23 ++
 rtl/bit32_seq_divider.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bit32_div_pkg.sv
// Shared types and constants for the sequential 32-bit divider.
package bit32_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    CALC,
    DONE
  } div_state_e;

  localparam int unsigned DIV_ITER  = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/bit32_ripple_carry_adder.sv
// Plain ripple-carry adder; the divider uses it as a subtractor (b inverted, c_in = 1).
module bit32_ripple_carry_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  logic [WIDTH:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = carry[WIDTH];

endmodule

// File: rtl/bit32_seq_divider.sv
// Restoring shift-subtract divider for MIPS32 DIV/DIVU, one quotient bit per clock.
// Define BIT32_DIV_SIGNED_EN to honour signed_in (DIV); otherwise every divide is unsigned.
module bit32_seq_divider
  import bit32_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             signed_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic [WIDTH-1:0] Q_out,
  output logic [WIDTH-1:0] R_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             div0_out
);

  localparam logic [CNT_W-1:0] LastCount = CNT_W'(DIV_ITER - 1);

  div_state_e       state_q;
  logic [WIDTH-1:0] a_q, b_q, dvd_q, dvs_q, rem_q;
  logic [CNT_W-1:0] count_q;

  logic [WIDTH-1:0] rem_shift, diff, rem_next, quot_next;
  logic [WIDTH-1:0] a_mag, b_mag, q_final, r_final;
  logic             carry, take;

  assign rem_shift = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};

  bit32_ripple_carry_adder #(
    .WIDTH(WIDTH)
  ) u_sub (
    .a    (rem_shift),
    .b    (~dvs_q),
    .c_in (1'b1),
    .sum  (diff),
    .c_out(carry)
  );

  // rem_q's MSB is shifted out of rem_shift; when set the true partial remainder
  // exceeds any divisor, so the subtraction always succeeds.
  assign take      = carry | rem_q[WIDTH-1];
  assign rem_next  = take ? diff : rem_shift;
  assign quot_next = {dvd_q[WIDTH-2:0], take};

`ifdef BIT32_DIV_SIGNED_EN
  logic sgn_q, neg_quot, neg_rem;

  // MIPS truncation: quotient sign is sign(A)^sign(B), remainder follows the dividend.
  assign neg_rem  = sgn_q & a_q[WIDTH-1];
  assign neg_quot = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign a_mag    = neg_rem ? -a_q : a_q;
  assign b_mag    = (sgn_q & b_q[WIDTH-1]) ? -b_q : b_q;
  assign q_final  = neg_quot ? -quot_next : quot_next;
  assign r_final  = neg_rem ? -rem_next : rem_next;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sgn_q <= 1'b0;
    end else if (state_q == IDLE && start_in) begin
      sgn_q <= signed_in;
    end
  end
`else
  logic unused_signed;

  assign unused_signed = signed_in;
  assign a_mag         = a_q;
  assign b_mag         = b_q;
  assign q_final       = quot_next;
  assign r_final       = rem_next;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      count_q  <= '0;
      Q_out    <= '0;
      R_out    <= '0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
      div0_out <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_in) begin
            a_q      <= A_in;
            b_q      <= B_in;
            busy_out <= 1'b1;
            div0_out <= 1'b0;
            state_q  <= PREP;
          end
        end
        PREP: begin
          if (b_q == '0) begin
            Q_out    <= WIDTH'(DIV0_QUOT);
            R_out    <= a_q;
            div0_out <= 1'b1;
            done_out <= 1'b1;
            state_q  <= DONE;
          end else begin
            dvd_q   <= a_mag;
            dvs_q   <= b_mag;
            rem_q   <= '0;
            count_q <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          rem_q   <= rem_next;
          dvd_q   <= quot_next;
          count_q <= count_q + CNT_W'(1);
          if (count_q == LastCount) begin
            Q_out    <= q_final;
            R_out    <= r_final;
            done_out <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_out <= 1'b0;
          busy_out <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
